cdb_arbiter: RTL and testbench
==============================

# cdb_arbiter

Round-robin arbiter that shares the single common data bus (CDB) among the out-of-order core's result producers: ALU reservation stations, load buffer and similar. Each producer hands over a completed result (16-bit data plus 3-bit reservation-station tag) through a valid/ready handshake into a one-entry holding slot. Each cycle the arbiter picks one pending slot and broadcasts it on a registered `CDB` struct from `lc3b_types`. It sits between the functional units and the register file, reservation stations and reorder logic that snoop the CDB.

## Interface
- `NUM_REQ`, default 4: number of requesters. Legal range is 2–8.
- `clk`  input  1: the single clock. All state updates on its rising edge.
- `reset`  input  1: synchronous, active-high reset.
- `req_valid`  input  `NUM_REQ`: requester i offers a result this cycle.
- `req_data`  input  `NUM_REQ`×16: result data. Requester i occupies bits [16i+15:16i].
- `req_tag`  input  `NUM_REQ`×3: producing tag. Requester i occupies bits [3i+2:3i].
- `req_ready`  output  `NUM_REQ`: requester i's slot can accept this cycle.
- `flush`  input  1: discard all pending and in-flight results (mispredict or exception).
- `cdb_out`  output  `CDB` (20 bits: valid, data[15:0], tag[2:0]): registered broadcast.

## Operation
- Per-requester state: `slot_valid[i]`, `slot_data[i]`, `slot_tag[i]`. Shared state: round-robin pointer `ptr`, which is ceil(log2 `NUM_REQ`) bits.
- Grant is combinational from registered state only, with no path from `req_valid`.
  - `grant` is one-hot: the first i with `slot_valid[i]=1`, searching from `ptr` upward and wrapping past `NUM_REQ-1` to 0.
  - No valid slot means `grant` is all zeros.
- `req_ready[i] = ~flush & ~reset & (~slot_valid[i] | grant[i])`. A slot being drained this cycle can refill in the same cycle.
- Acceptance: `req_valid[i] & req_ready[i]` loads the slot with `req_data`/`req_tag` at the edge and sets `slot_valid[i]=1`.
- A granted slot that is not refilled clears `slot_valid[i]` at the edge. A granted slot that is refilled in the same cycle stays valid and holds the new value.
- CDB register at each edge:
  - With a grant: `cdb_out` ← {1, `slot_data[w]`, `slot_tag[w]`}, where w is the winner.
  - Without a grant: `cdb_out.valid` ← 0. `data` and `tag` hold their previous values; consumers must ignore them.
- Pointer: on a grant, `ptr` ← (w+1) mod `NUM_REQ`. Otherwise `ptr` holds.
- `flush`:
  - At the edge: all `slot_valid` ← 0 and `cdb_out.valid` ← 0. No grant is broadcast; the result that would have been granted is dropped. `ptr` holds.
  - While `flush` is high, `req_ready` is 0 and no acceptance occurs.
- `reset`: all `slot_valid` ← 0, `cdb_out` ← 0 (all 20 bits), `ptr` ← 0. `req_ready` reads 0 during the reset cycle. Reset overrides `flush` and requests.
- Priority of simultaneous events: `reset` > `flush` > grant/accept.

## Timing
- Latency: a result accepted at edge k is eligible for grant in the cycle after edge k. If granted then, it appears on `cdb_out` (valid=1) from edge k+1, which is one cycle of bus latency.
- Throughput:
  - Exactly one CDB broadcast per cycle while any slot is pending.
  - A single requester streaming alone sustains one result per cycle through drain-and-refill.
- Fairness: with all N slots continuously full, each requester is granted exactly once in every N consecutive cycles.
- Worst-case wait for a pending slot is N−1 cycles before its grant.
- `cdb_out` is held for exactly one cycle per grant. There are no back-to-back duplicates of the same result.
- Reset value of every output: `cdb_out` = 20'h0. `req_ready` = 0 while `reset` is high, and all 1s in the first cycle after reset.

## Test plan
- Single request: after reset, requester 2 offers data 16'h1234 with tag 3'd5 for one cycle. Required: `req_ready[2]`=1, acceptance at edge k, `cdb_out` = {1, 16'h1234, 3'd5} after edge k+1, then valid=0.
- Simultaneous: all 4 requesters offer in the same cycle with tags 0–3 and `ptr`=0. Required: broadcasts tags 0,1,2,3 on four consecutive cycles, `ptr` ends at 0, and `req_ready[i]` returns to 1 as each slot drains.
- Round-robin fairness: hold all `req_valid`=1 with distinct data for 40 cycles. Required: grant sequence 0,1,2,3 repeating, with each requester granted exactly 10 times.
- Streaming single requester: requester 1 asserts valid for 8 cycles with data 1..8. Required: `req_ready[1]` stays 1 throughout, and `cdb_out` carries data 1..8 on 8 consecutive cycles with no gaps.
- Flush mid-operation:
  - Stimulus: slots 0 and 3 pending, assert `flush` for one cycle while requester 1 offers.
  - Required: no broadcast for that edge, and requester 1 is not accepted (`req_ready`=0).
  - Required: all slots are empty afterwards, and `cdb_out.valid`=0 until new requests arrive.
- Reset mid-operation: with 3 slots pending and `ptr`=2, assert `reset` for one cycle. Required: `cdb_out`=0, no further broadcasts, and a new request from requester 3 afterwards is granted with `ptr` advancing from 0 to 0 (winner 3, so (3+1) mod 4 = 0).

Source files
------------

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing the common data bus among result producers.
// One holding slot per requester; one registered broadcast per cycle.

package lc3b_types;
  typedef struct packed {
    logic        valid;
    logic [15:0] data;
    logic [2:0]  tag;
  } CDB;
endpackage

// One-entry holding slot for a single producer.
module cdb_slot (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        load,
  input  logic        drain,
  input  logic [15:0] in_data,
  input  logic [2:0]  in_tag,
  output logic        valid,
  output logic [15:0] data,
  output logic [2:0]  tag
);
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      valid <= 1'b0;
    end else if (load) begin
      // a load wins over a same-cycle drain so the slot refills seamlessly
      valid <= 1'b1;
      data  <= in_data;
      tag   <= in_tag;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end
endmodule

module cdb_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*16-1:0]   req_data,
  input  logic [NUM_REQ*3-1:0]    req_tag,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic                    flush,
  output lc3b_types::CDB          cdb_out
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]       slot_valid;
  logic [NUM_REQ-1:0][15:0] slot_data;
  logic [NUM_REQ-1:0][2:0]  slot_tag;
  logic [NUM_REQ-1:0]       grant;
  logic [NUM_REQ-1:0]       load;
  logic [PW-1:0]            ptr;
  logic [PW-1:0]            win;

  // Grant depends only on registered slot state and ptr.
  always_comb begin
    int  idx;
    logic found;
    grant = '0;
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && slot_valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        win        = PW'(idx);
      end
    end
  end

  assign req_ready = {NUM_REQ{~flush & ~reset}} & (~slot_valid | grant);
  assign load      = req_valid & req_ready;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
    cdb_slot u_slot (
      .clk     (clk),
      .reset   (reset),
      .flush   (flush),
      .load    (load[i]),
      .drain   (grant[i]),
      .in_data (req_data[16*i +: 16]),
      .in_tag  (req_tag[3*i +: 3]),
      .valid   (slot_valid[i]),
      .data    (slot_data[i]),
      .tag     (slot_tag[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cdb_out <= '0;
      ptr     <= '0;
    end else if (flush) begin
      cdb_out.valid <= 1'b0;
    end else if (|grant) begin
      cdb_out <= {1'b1, slot_data[win], slot_tag[win]};
      ptr     <= (win == PW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
    end else begin
      // data/tag are left stale; consumers look only at valid
      cdb_out.valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed vector table, fairness/streaming sequences,
// and random traffic checked against a slot-level reference model.
module tb_cdb_arbiter;
  localparam int N = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          flush = 1'b0;
  logic [N-1:0]  req_valid = '0;
  logic [N*16-1:0] req_data = '0;
  logic [N*3-1:0]  req_tag = '0;
  logic [N-1:0]  req_ready;
  lc3b_types::CDB cdb_out;

  cdb_arbiter #(.NUM_REQ(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_tag   (req_tag),
    .req_ready (req_ready),
    .flush     (flush),
    .cdb_out   (cdb_out)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: what each slot holds and whose turn it is
  bit          m_valid [N];
  logic [15:0] m_data  [N];
  logic [2:0]  m_tag   [N];
  int          m_ptr = 0;
  logic [19:0] m_cdb = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: drive after negedge, sample ready before the edge and cdb after it.
  task automatic apply(input logic rst, input logic fl, input logic [3:0] v,
                       input logic [63:0] d, input logic [11:0] t,
                       output logic [3:0] rdy, output logic [19:0] cdb,
                       output logic [3:0] erdy, output logic [19:0] ecdb);
    int w;
    @(negedge clk);
    reset = rst; flush = fl; req_valid = v; req_data = d; req_tag = t;
    w = -1;
    for (int k = 0; k < N; k++)
      if (w < 0 && m_valid[(m_ptr + k) % N]) w = (m_ptr + k) % N;
    for (int i = 0; i < N; i++)
      erdy[i] = !rst && !fl && (!m_valid[i] || w == i);
    #1 rdy = req_ready;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < N; i++) m_valid[i] = 0;
      m_cdb = '0; m_ptr = 0;
    end else if (fl) begin
      for (int i = 0; i < N; i++) m_valid[i] = 0;
      m_cdb[19] = 1'b0;
    end else begin
      if (w >= 0) begin
        m_cdb = {1'b1, m_data[w], m_tag[w]};
        m_ptr = (w + 1) % N;
        m_valid[w] = 0;
      end else m_cdb[19] = 1'b0;
      for (int i = 0; i < N; i++)
        if (v[i] && erdy[i]) begin
          m_valid[i] = 1; m_data[i] = d[16*i +: 16]; m_tag[i] = t[3*i +: 3];
        end
    end
    ecdb = m_cdb;
    #1 cdb = cdb_out;
  endtask

  typedef struct {
    logic        rst;
    logic        fl;
    logic [3:0]  v;
    logic [63:0] d;
    logic [11:0] t;
    logic [3:0]  er;
    logic [19:0] ec;
  } vec_t;

  vec_t tbl[22];

  function automatic vec_t mk(logic rst, logic fl, logic [3:0] v, logic [63:0] d,
                              logic [11:0] t, logic [3:0] er, logic [19:0] ec);
    vec_t r;
    r.rst = rst; r.fl = fl; r.v = v; r.d = d; r.t = t; r.er = er; r.ec = ec;
    return r;
  endfunction

  initial begin
    logic [3:0]  rdy, erdy;
    logic [19:0] cdb, ecdb;
    int cnt [N];
    int nb;

    // single request from requester 2
    tbl[0]  = mk(1, 0, 4'b0000, 64'h0, 12'h0, 4'b0000, 20'h00000);
    tbl[1]  = mk(0, 0, 4'b0100, 64'h0000_1234_0000_0000, {3'd0, 3'd5, 3'd0, 3'd0}, 4'b1111, 20'h00000);
    tbl[2]  = mk(0, 0, 4'b0000, 64'h0, 12'h0, 4'b1111, 20'h891A5);
    tbl[3]  = mk(0, 0, 4'b0000, 64'h0, 12'h0, 4'b1111, 20'h091A5);
    // all four at once from ptr=0
    tbl[4]  = mk(1, 0, 4'b0000, 64'h0, 12'h0, 4'b0000, 20'h00000);
    tbl[5]  = mk(0, 0, 4'b1111, 64'hA003_A002_A001_A000, {3'd3, 3'd2, 3'd1, 3'd0}, 4'b1111, 20'h00000);
    tbl[6]  = mk(0, 0, 4'b0000, 64'h0, 12'h0, 4'b0001, 20'hD0000);
    tbl[7]  = mk(0, 0, 4'b0000, 64'h0, 12'h0, 4'b0011, 20'hD0009);
    tbl[8]  = mk(0, 0, 4'b0000, 64'h0, 12'h0, 4'b0111, 20'hD0012);
    tbl[9]  = mk(0, 0, 4'b0000, 64'h0, 12'h0, 4'b1111, 20'hD001B);
    tbl[10] = mk(0, 0, 4'b0000, 64'h0, 12'h0, 4'b1111, 20'h5001B);
    // flush with slots 0 and 3 pending while requester 1 offers
    tbl[11] = mk(0, 0, 4'b1001, 64'h0C00_0000_0000_0B00, {3'd7, 3'd0, 3'd0, 3'd6}, 4'b1111, 20'h5001B);
    tbl[12] = mk(0, 1, 4'b0010, 64'h0000_0000_0D00_0000, {3'd0, 3'd0, 3'd1, 3'd0}, 4'b0000, 20'h5001B);
    tbl[13] = mk(0, 0, 4'b0000, 64'h0, 12'h0, 4'b1111, 20'h5001B);
    tbl[14] = mk(0, 0, 4'b0000, 64'h0, 12'h0, 4'b1111, 20'h5001B);
    // reset with three slots pending and ptr=2
    tbl[15] = mk(0, 0, 4'b0010, 64'h0000_0000_0111_0000, {3'd0, 3'd0, 3'd1, 3'd0}, 4'b1111, 20'h5001B);
    tbl[16] = mk(0, 0, 4'b1101, 64'h0223_0222_0000_0220, {3'd3, 3'd2, 3'd0, 3'd0}, 4'b1111, 20'h80889);
    tbl[17] = mk(1, 0, 4'b0000, 64'h0, 12'h0, 4'b0000, 20'h00000);
    tbl[18] = mk(0, 0, 4'b1000, 64'h0333_0000_0000_0000, {3'd3, 3'd0, 3'd0, 3'd0}, 4'b1111, 20'h00000);
    tbl[19] = mk(0, 0, 4'b0000, 64'h0, 12'h0, 4'b1111, 20'h8199B);
    // ptr must now be 0: slots 0 and 3 both pending, 0 wins first
    tbl[20] = mk(0, 0, 4'b1001, 64'h0555_0000_0000_0444, {3'd5, 3'd0, 3'd0, 3'd4}, 4'b1111, 20'h0199B);
    tbl[21] = mk(0, 0, 4'b0000, 64'h0, 12'h0, 4'b0111, 20'h82224);

    for (int i = 0; i < 22; i++) begin
      apply(tbl[i].rst, tbl[i].fl, tbl[i].v, tbl[i].d, tbl[i].t, rdy, cdb, erdy, ecdb);
      chk($sformatf("vec%0d_ready", i), 32'(rdy), 32'(tbl[i].er));
      chk($sformatf("vec%0d_cdb", i), 32'(cdb), 32'(tbl[i].ec));
    end

    // fairness: all requesters held valid for 40 broadcast cycles
    apply(1, 0, 4'b0000, 64'h0, 12'h0, rdy, cdb, erdy, ecdb);
    for (int i = 0; i < N; i++) cnt[i] = 0;
    nb = 0;
    for (int c = 0; c < 41; c++) begin
      apply(0, 0, 4'b1111, {16'(c), 16'(c + 100), 16'(c + 200), 16'(c + 300)},
            {3'd3, 3'd2, 3'd1, 3'd0}, rdy, cdb, erdy, ecdb);
      if (c > 0) begin
        chk($sformatf("fair%0d_valid", c), 32'(cdb[19]), 32'd1);
        chk($sformatf("fair%0d_tag", c), 32'(cdb[2:0]), 32'(nb % N));
        if (cdb[19]) cnt[cdb[2:0] % N]++;
        nb++;
      end
    end
    for (int i = 0; i < N; i++) chk($sformatf("fair_count%0d", i), 32'(cnt[i]), 32'd10);

    // single requester streaming data 1..8 with no gaps
    apply(1, 0, 4'b0000, 64'h0, 12'h0, rdy, cdb, erdy, ecdb);
    for (int j = 0; j < 9; j++) begin
      apply(0, 0, (j < 8) ? 4'b0010 : 4'b0000, {32'h0, 16'(j + 1), 16'h0},
            {3'd0, 3'd0, 3'd2, 3'd0}, rdy, cdb, erdy, ecdb);
      if (j < 8) chk($sformatf("stream%0d_ready1", j), 32'(rdy[1]), 32'd1);
      if (j > 0) begin
        chk($sformatf("stream%0d_valid", j), 32'(cdb[19]), 32'd1);
        chk($sformatf("stream%0d_data", j), 32'(cdb[18:3]), 32'(j));
      end
    end

    // random traffic against the model
    for (int c = 0; c < 400; c++) begin
      logic r, f;
      r = ($urandom_range(0, 49) == 0);
      f = ($urandom_range(0, 19) == 0);
      apply(r, f, 4'($urandom), {$urandom, $urandom}, 12'($urandom), rdy, cdb, erdy, ecdb);
      chk($sformatf("rand%0d_ready", c), 32'(rdy), 32'(erdy));
      chk($sformatf("rand%0d_cdb", c), 32'(cdb), 32'(ecdb));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
